// File: rtl/fpu_flag_status.sv
// rtl/fpu_flag_status.sv - IEEE-754 exception status stage: sticky flags, cause, trap enables, trap handshake
module fpu_flag_status #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [4:0]       res_flags,
    input  logic [TAG_W-1:0] res_tag,
    output logic             res_ready,
    input  logic             csr_we,
    input  logic [1:0]       csr_sel,
    input  logic [4:0]       csr_wdata,
    output logic [4:0]       csr_rdata,
    input  logic             flag_clr,
    output logic             trap_req,
    output logic [4:0]       trap_cause,
    output logic [TAG_W-1:0] trap_tag,
    input  logic             trap_ack
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t     state;
    logic [4:0] flags;
    logic [4:0] trap_en;
    logic [4:0] cause;
    logic       accept;
    logic [4:0] hit;
    logic [4:0] flags_base;
    logic [4:0] flags_merge;

    assign accept = res_valid & res_ready;
    assign hit    = res_flags & trap_en;

    // Trapping bits stay out of the sticky set; the trap handler owns them.
    always_comb begin
        flags_base  = flags;
        flags_merge = '0;
        if (flag_clr) begin
            flags_base = '0;
        end else if (csr_we && csr_sel == 2'b00) begin
            flags_base = csr_wdata;
        end
        if (accept) begin
            flags_merge = res_flags & ~trap_en;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_sel)
            2'b00:   csr_rdata = flags;
            2'b01:   csr_rdata = trap_en;
            2'b10:   csr_rdata = cause;
            default: csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flags      <= '0;
            trap_en    <= '0;
            cause      <= '0;
            trap_cause <= '0;
            trap_tag   <= '0;
            res_ready  <= 1'b1;
            trap_req   <= 1'b0;
        end else begin
            flags <= flags_base | flags_merge;
            if (csr_we && csr_sel == 2'b01) begin
                trap_en <= csr_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cause <= res_flags;
                        if (|hit) begin
                            trap_cause <= hit;
                            trap_tag   <= res_tag;
                            state      <= PEND;
                            res_ready  <= 1'b0;
                            trap_req   <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (trap_ack) begin
                        state     <= IDLE;
                        res_ready <= 1'b1;
                        trap_req  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_ready <= 1'b1;
                    trap_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
